// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared types and constants for the elevator controller:
//                FSM state encoding and the seven-segment digit table.
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    // Active-high segments {g,f,e,d,c,b,a}, entry i shows decimal digit i
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b1101111,   // 9
        7'b1111111,   // 8
        7'b0000111,   // 7
        7'b1111101,   // 6
        7'b1101101,   // 5
        7'b1100110,   // 4
        7'b1001111,   // 3
        7'b1011011,   // 2
        7'b0000110,   // 1
        7'b0111111    // 0
    };

    // Digit lookup; anything outside 0..9 blanks the display
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] seg;
        seg = 7'b0000000;
        if (d <= 4'd9) begin
            seg = SEG_DIGITS[d];
        end
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_tick.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_tick
//  Description : Movement-tick prescaler. Counts 0..DIV-1 while enabled and
//                emits a one-cycle pulse on the cycle the count wraps to 0.
//                Reset is asynchronous and active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Free-running divider; holds its count and suppresses the pulse while disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (en) begin
            if (r_cnt == C_LAST) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/elevator_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_ctrl
//  Description : Single-car elevator controller. Latches floor requests,
//                chooses a travel direction, steps one floor per movement
//                tick and holds the door open for a fixed number of ticks.
//                Reset is asynchronous and active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_ctrl #(
    parameter int N_FLOORS   = 4,
    parameter int TICK_DIV   = 50000000,
    parameter int DOOR_TICKS = 3,
    parameter int CNT_W      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        stop,
    input  logic [N_FLOORS-1:0]         req,
    output logic                        tick_out,
    output logic [$clog2(N_FLOORS)-1:0] floor,
    output logic [6:0]                  floor_display,
    output logic                        dir_up,
    output logic                        moving,
    output logic                        door_open,
    output logic [N_FLOORS-1:0]         pending,
    output logic [CNT_W-1:0]            changes_count
);

    import elevator_pkg::*;

    localparam int            FW          = $clog2(N_FLOORS);
    localparam int            DW          = $clog2(DOOR_TICKS + 1);
    localparam logic [FW-1:0] C_TOP_FLOOR = FW'(N_FLOORS - 1);
    localparam logic [DW-1:0] C_DOOR_LOAD = DW'(DOOR_TICKS);

    state_t                r_state,    w_state_nx;
    logic [FW-1:0]         r_floor,    w_floor_nx;
    logic                  r_dir_up,   w_dir_nx;
    logic [DW-1:0]         r_door_cnt, w_door_nx;
    logic [CNT_W-1:0]      r_changes,  w_changes_nx;
    logic [N_FLOORS-1:0]   r_pending,  w_pending_nx;
    logic [N_FLOORS-1:0]   w_clear;
    logic [FW-1:0]         w_step_floor;
    logic                  w_at_end;
    logic                  w_tick;

    elevator_tick #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (w_tick)
    );

    // True when some request lies strictly above (up=1) or below (up=0) floor f
    function automatic logic any_beyond(input logic [N_FLOORS-1:0] p,
                                        input logic [FW-1:0]       f,
                                        input logic                up);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Next-state, motion and request-bookkeeping decisions
    always_comb begin
        w_state_nx   = r_state;
        w_floor_nx   = r_floor;
        w_dir_nx     = r_dir_up;
        w_door_nx    = r_door_cnt;
        w_changes_nx = r_changes;
        w_clear      = '0;
        w_step_floor = r_dir_up ? (r_floor + FW'(1)) : (r_floor - FW'(1));
        w_at_end     = r_dir_up ? (r_floor == C_TOP_FLOOR) : (r_floor == '0);

        if (!stop) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pending[r_floor]) begin
                        w_state_nx = ST_DOOR;
                        w_door_nx  = C_DOOR_LOAD;
                    end else if (any_beyond(r_pending, r_floor, r_dir_up)) begin
                        w_state_nx = ST_MOVE;
                    end else if (any_beyond(r_pending, r_floor, !r_dir_up)) begin
                        w_dir_nx   = !r_dir_up;
                        w_state_nx = ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (w_tick) begin
                        if (w_at_end) begin
                            // Nothing can lie beyond an end floor; never step past it
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_floor_nx = w_step_floor;
                            if (r_changes != {CNT_W{1'b1}}) begin
                                w_changes_nx = r_changes + CNT_W'(1);
                            end
                            if (r_pending[w_step_floor]) begin
                                w_state_nx = ST_DOOR;
                                w_door_nx  = C_DOOR_LOAD;
                            end else if (any_beyond(r_pending, w_step_floor, r_dir_up)) begin
                                w_state_nx = ST_MOVE;
                            end else begin
                                w_state_nx = ST_IDLE;
                            end
                        end
                    end
                end
                ST_DOOR: begin
                    if (w_tick) begin
                        if (r_door_cnt <= DW'(1)) begin
                            w_door_nx  = '0;
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_door_nx  = r_door_cnt - DW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end

        // The floor whose door is open (or opening) is served: clear beats a new request
        if (r_state == ST_DOOR) begin
            w_clear[r_floor] = 1'b1;
        end
        if (w_state_nx == ST_DOOR) begin
            w_clear[w_floor_nx] = 1'b1;
        end
        w_pending_nx = (r_pending | req) & ~w_clear;
    end

    // Controller state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_floor    <= '0;
            r_dir_up   <= 1'b1;
            r_door_cnt <= '0;
            r_changes  <= '0;
            r_pending  <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_floor    <= w_floor_nx;
            r_dir_up   <= w_dir_nx;
            r_door_cnt <= w_door_nx;
            r_changes  <= w_changes_nx;
            r_pending  <= w_pending_nx;
        end
    end

    assign tick_out      = w_tick;
    assign floor         = r_floor;
    assign floor_display = seg_digit(4'(r_floor));
    assign dir_up        = r_dir_up;
    assign moving        = (r_state == ST_MOVE);
    assign door_open     = (r_state == ST_DOOR);
    assign pending       = r_pending;
    assign changes_count = r_changes;

endmodule
`default_nettype wire

// File: tb/tb_elevator_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elevator_ctrl
//  Description : Self-checking bench for elevator_ctrl: directed checkpoint
//                table, hand-written corner sequences and random stimulus
//                compared against a behavioural model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_elevator_ctrl;

    localparam int N    = 4;
    localparam int TDIV = 4;
    localparam int DT   = 2;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    localparam logic [6:0] SEG [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         en   = 1'b0;
    logic         stop = 1'b0;
    logic [N-1:0] req  = '0;

    logic         tick_out, dir_up, moving, door_open;
    logic [1:0]   floor;
    logic [6:0]   floor_display;
    logic [N-1:0] pending;
    logic [3:0]   changes_count;

    logic         s_tick_out, s_dir_up, s_moving, s_door_open;
    logic [1:0]   s_floor;
    logic [6:0]   s_floor_display;
    logic [N-1:0] s_pending;
    logic [1:0]   s_changes;

    int n_vec;
    int n_err;

    // behavioural model
    int           m_floor, m_state, m_door, m_chg, m_pc;
    bit           m_up, m_tick;
    bit [N-1:0]   m_pend;

    elevator_ctrl #(.N_FLOORS(N), .TICK_DIV(TDIV), .DOOR_TICKS(DT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .stop(stop), .req(req),
        .tick_out(tick_out), .floor(floor), .floor_display(floor_display),
        .dir_up(dir_up), .moving(moving), .door_open(door_open),
        .pending(pending), .changes_count(changes_count)
    );

    elevator_ctrl #(.N_FLOORS(N), .TICK_DIV(TDIV), .DOOR_TICKS(DT), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .en(en), .stop(stop), .req(req),
        .tick_out(s_tick_out), .floor(s_floor), .floor_display(s_floor_display),
        .dir_up(s_dir_up), .moving(s_moving), .door_open(s_door_open),
        .pending(s_pending), .changes_count(s_changes)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit req_beyond(input bit [N-1:0] p, input int f, input bit up);
        for (int i = 0; i < N; i++) begin
            if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_state = M_IDLE; m_up = 1'b1; m_door = 0;
        m_chg = 0; m_pend = '0; m_pc = 0; m_tick = 1'b0;
    endtask

    // One clock edge of the specified behaviour, from pre-edge state
    task automatic model_step(input bit [N-1:0] r, input bit e, input bit s);
        int nf, ns, nd;
        bit nu;
        bit [N-1:0] np;
        nf = m_floor; ns = m_state; nd = m_door; nu = m_up;
        if (!s) begin
            if (m_state == M_IDLE) begin
                if (m_pend[m_floor]) begin
                    ns = M_DOOR; nd = DT;
                end else if (req_beyond(m_pend, m_floor, m_up)) begin
                    ns = M_MOVE;
                end else if (req_beyond(m_pend, m_floor, !m_up)) begin
                    nu = !m_up; ns = M_MOVE;
                end
            end else if (m_state == M_MOVE && m_tick) begin
                nf = m_floor + (m_up ? 1 : -1);
                if (nf < 0 || nf >= N) begin
                    nf = m_floor; ns = M_IDLE;
                end else begin
                    m_chg++;
                    if (m_pend[nf]) begin
                        ns = M_DOOR; nd = DT;
                    end else if (req_beyond(m_pend, nf, m_up)) begin
                        ns = M_MOVE;
                    end else begin
                        ns = M_IDLE;
                    end
                end
            end else if (m_state == M_DOOR && m_tick) begin
                nd = m_door - 1;
                if (nd <= 0) begin
                    nd = 0; ns = M_IDLE;
                end
            end
        end
        np = m_pend | r;
        if (m_state == M_DOOR) np[m_floor] = 1'b0;
        if (ns == M_DOOR) np[nf] = 1'b0;
        m_floor = nf; m_state = ns; m_door = nd; m_up = nu; m_pend = np;
        if (e) begin
            m_pc   = (m_pc + 1) % TDIV;
            m_tick = (m_pc == 0);
        end else begin
            m_tick = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("floor",     int'(floor),         m_floor);
        chk("moving",    int'(moving),        int'(m_state == M_MOVE));
        chk("door_open", int'(door_open),     int'(m_state == M_DOOR));
        chk("dir_up",    int'(dir_up),        int'(m_up));
        chk("pending",   int'(pending),       int'(m_pend));
        chk("changes",   int'(changes_count), (m_chg > 15) ? 15 : m_chg);
        chk("changes_w2", int'(s_changes),    (m_chg > 3) ? 3 : m_chg);
        chk("tick_out",  int'(tick_out),      int'(m_tick));
        chk("display",   int'(floor_display), int'(SEG[m_floor]));
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic e, input logic s);
        req = r; en = e; stop = s;
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step(r, e, s);
        #1;
        check_all();
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        chk({tag, "_floor"},   int'(floor),         0);
        chk({tag, "_display"}, int'(floor_display), 7'b0111111);
        chk({tag, "_moving"},  int'(moving),        0);
        chk({tag, "_door"},    int'(door_open),     0);
        chk({tag, "_dir"},     int'(dir_up),        1);
        chk({tag, "_pending"}, int'(pending),       0);
        chk({tag, "_changes"}, int'(changes_count), 0);
        chk({tag, "_tick"},    int'(tick_out),      0);
    endtask

    typedef struct {
        logic [N-1:0] r;
        bit           e;
        bit           s;
        int           cyc;
        int           f;
        int           mv;
        int           dr;
        int           up;
        int           pd;
        int           chg;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int k;
        logic [N-1:0] rr;
        logic ee, ss;

        n_vec = 0;
        n_err = 0;
        model_reset();

        // checkpoints counted in clock edges after reset release
        tbl[0]  = '{4'b0100, 1'b1, 1'b0, 1, 0, 0, 0, 1, 4'b0100, 0};
        tbl[1]  = '{4'b0000, 1'b1, 1'b0, 1, 0, 1, 0, 1, 4'b0100, 0};
        tbl[2]  = '{4'b0000, 1'b1, 1'b0, 3, 1, 1, 0, 1, 4'b0100, 1};
        tbl[3]  = '{4'b0000, 1'b1, 1'b0, 4, 2, 0, 1, 1, 4'b0000, 2};
        tbl[4]  = '{4'b0000, 1'b1, 1'b0, 4, 2, 0, 1, 1, 4'b0000, 2};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 4, 2, 0, 0, 1, 4'b0000, 2};
        tbl[6]  = '{4'b1001, 1'b1, 1'b0, 1, 2, 0, 0, 1, 4'b1001, 2};
        tbl[7]  = '{4'b0000, 1'b1, 1'b0, 1, 2, 1, 0, 1, 4'b1001, 2};
        tbl[8]  = '{4'b0000, 1'b1, 1'b0, 2, 3, 0, 1, 1, 4'b0001, 3};
        tbl[9]  = '{4'b0000, 1'b1, 1'b0, 8, 3, 0, 0, 1, 4'b0001, 3};
        tbl[10] = '{4'b0000, 1'b1, 1'b0, 1, 3, 1, 0, 0, 4'b0001, 3};
        tbl[11] = '{4'b0000, 1'b1, 1'b0, 3, 2, 1, 0, 0, 4'b0001, 4};
        tbl[12] = '{4'b0000, 1'b1, 1'b0, 8, 0, 0, 1, 0, 4'b0000, 6};
        tbl[13] = '{4'b0001, 1'b1, 1'b0, 4, 0, 0, 1, 0, 4'b0000, 6};
        tbl[14] = '{4'b0000, 1'b1, 1'b0, 4, 0, 0, 0, 0, 4'b0000, 6};

        #2;
        do_reset("por");
        cycle('0, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        rst = 1'b1;

        // directed up-trip, reversal and door-request absorption
        for (int i = 0; i < 15; i++) begin
            for (int c = 0; c < tbl[i].cyc; c++) cycle(tbl[i].r, tbl[i].e, tbl[i].s);
            chk($sformatf("tbl%0d_floor", i),   int'(floor),         tbl[i].f);
            chk($sformatf("tbl%0d_moving", i),  int'(moving),        tbl[i].mv);
            chk($sformatf("tbl%0d_door", i),    int'(door_open),     tbl[i].dr);
            chk($sformatf("tbl%0d_dir", i),     int'(dir_up),        tbl[i].up);
            chk($sformatf("tbl%0d_pending", i), int'(pending),       tbl[i].pd);
            chk($sformatf("tbl%0d_changes", i), int'(changes_count), tbl[i].chg);
            chk($sformatf("tbl%0d_chg_w2", i),  int'(s_changes),     (tbl[i].chg > 3) ? 3 : tbl[i].chg);
        end

        // reset pulse while moving through floor 2
        cycle(4'b1000, 1'b1, 1'b0);
        k = 0;
        while (!(m_floor == 2 && m_state == M_MOVE) && k < 40) begin
            cycle('0, 1'b1, 1'b0);
            k++;
        end
        chk("s046_reached", int'(k < 40), 1);
        chk("s046_pre_floor", int'(floor), 2);
        chk("s046_pre_moving", int'(moving), 1);
        do_reset("s046");
        cycle('0, 1'b1, 1'b0);
        rst = 1'b1;

        // emergency stop in the middle of a move
        cycle(4'b1000, 1'b1, 1'b0);
        k = 0;
        while (!(m_floor == 1 && m_state == M_MOVE) && k < 40) begin
            cycle('0, 1'b1, 1'b0);
            k++;
        end
        chk("s043_reached", int'(k < 40), 1);
        for (int c = 0; c < 10; c++) begin
            cycle('0, 1'b1, 1'b1);
            chk("s043_hold_floor", int'(floor), 1);
            chk("s043_hold_moving", int'(moving), 1);
        end
        k = 0;
        while (m_floor == 1 && k < 2 * TDIV + 2) begin
            cycle('0, 1'b1, 1'b0);
            k++;
        end
        chk("s043_resume_latency_ok", int'(k >= 1 && k <= TDIV), 1);
        chk("s043_resume_floor", int'(floor), 2);
        chk("s043_resume_moving", int'(moving), 1);
        k = 0;
        while (!(m_state == M_IDLE) && k < 60) begin
            cycle('0, 1'b1, 1'b0);
            k++;
        end
        chk("s043_idle_floor", int'(floor), 3);

        // prescaler disabled, then counter saturation on the narrow instance
        cycle(4'b0001, 1'b1, 1'b0);
        for (int c = 0; c < 20; c++) begin
            cycle('0, 1'b0, 1'b0);
            chk("s045_no_tick", int'(tick_out), 0);
            chk("s045_no_motion", int'(floor), 3);
        end
        k = 0;
        while (!(m_state == M_IDLE && m_floor == 0) && k < 80) begin
            cycle('0, 1'b1, 1'b0);
            k++;
        end
        chk("s045_floor0", int'(floor), 0);
        chk("s045_changes", int'(changes_count), 6);
        chk("s045_changes_sat", int'(s_changes), 3);

        // random stimulus against the model
        for (int c = 0; c < 3000; c++) begin
            rr = '0;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 15) == 0) rr[b] = 1'b1;
            end
            ee = ($urandom_range(0, 9) != 0);
            ss = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 599) == 0) begin
                do_reset("rnd_rst");
                cycle(rr, ee, ss);
                rst = 1'b1;
            end else begin
                cycle(rr, ee, ss);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
